bit_stuffer_param: RTL
======================

// Module: bit_stuffer_param
// PURPOSE
//  Parametrised serial bit stuffer for the USB transmit path, between the packet serialiser and the NRZI encoder.
//  Counts consecutive RUN_BIT bits. After RUN_LEN of them, inserts one ~RUN_BIT bit and back-pressures upstream for that bit time.
//  Adds three things: a valid/ready handshake, a stuff enable/bypass mode, and a saturating count of stuffed bits.
// PARAMETERS
//  RUN_LEN      6     consecutive RUN_BIT bits that trigger a stuff; legal range 2..15
//  RUN_BIT      1'b1  bit value whose run is counted; the stuffed bit is ~RUN_BIT
//  STUFF_CNT_W  8     width of stuff_count
//  localparam RUN_W = $clog2(RUN_LEN+1)  width of the run counter
// PORTS
//  clk          in   1            system clock
//  n_rst        in   1            synchronous active-low reset
//  shift_en     in   1            one-cycle bit-time strobe from the bit timer
//  stuff_en     in   1            1 = stuffing active; 0 = passthrough
//  flush        in   1            abort; clears the run and any pending stuff
//  serial_in    in   1            bit offered by upstream
//  in_valid     in   1            serial_in is valid
//  in_ready     out  1            combinational; bit accepted when in_valid & in_ready
//  serial_out   out  1            registered output bit
//  out_valid    out  1            one-cycle pulse; serial_out is a new bit
//  stuffing     out  1            with out_valid: the current bit is a stuffed bit
//  stuff_count  out  STUFF_CNT_W  saturating count of stuffed bits emitted
//  count_clr    in   1            synchronous clear of stuff_count
// BEHAVIOUR
//  Reset (n_rst=0 at posedge):
//   - state=ST_RUN, run=0.
//   - serial_out, out_valid, stuffing and stuff_count all 0.
//   - in_ready=0 whenever n_rst=0.
//   - Reset mid-packet drops any pending stuff.
//  FSM ST_RUN:
//   - in_ready = shift_en.
//   - On accept: serial_out<=serial_in, out_valid<=1, stuffing<=0.
//   - If serial_in==RUN_BIT: run<=run+1. Else run<=0.
//   - If stuff_en && serial_in==RUN_BIT && run==RUN_LEN-1: run<=0, go to ST_STUFF.
//  FSM ST_STUFF:
//   - in_ready=0.
//   - On shift_en: serial_out<=~RUN_BIT, out_valid<=1, stuffing<=1, run<=0, stuff_count+1, go to ST_RUN.
//  Latency: exactly 1 clk from accept/stuff slot to serial_out; out_valid is 0 on every other cycle.
//  shift_en with in_valid=0 in ST_RUN: no output, run held (idle gaps do not break a run).
//  stuff_en=0 in ST_RUN: run forced to 0 every cycle and no stuff is ever scheduled.
//   - stuff_en falling while in ST_STUFF: the pending stuff bit is still emitted.
//  flush (highest priority after reset):
//   - run<=0, state<=ST_RUN, out_valid<=0, in_ready=0 that cycle.
//   - The pending stuff is discarded; stuff_count is unchanged.
//  stuff_count: saturates at all-ones.
//   - count_clr alone -> 0.
//   - count_clr and a stuff event in the same cycle -> 1 (the event is never lost).
//  serial_out holds its value between pulses.
// STRUCTURE
//  Package usb_tx_pkg:
//   - typedef enum logic {ST_RUN, ST_STUFF} stuff_state_t
//   - localparam int USB_STUFF_RUN = 6
//  Sub-module sat_counter #(W), instantiated for stuff_count.
//   - Ports: clk, n_rst, clr, inc, count. Clear-plus-increment yields 1.
//  Run counter, FSM and output register stay in this module.
// TESTING (RUN_LEN=6, RUN_BIT=1, shift_en every cycle unless noted)
//  1. 7 ones, stuff_en=1 -> out 1,1,1,1,1,1,0(stuffing=1),1.
//     in_ready=0 in the stuff slot; stuff_count=1.
//  2. Bits 1,1,1,1,1,0,1,1 -> passed unchanged; no stuffing pulse; stuff_count=0.
//  3. 12 ones -> out 1x6,0,1x6,0; stuff_count=2.
//     Repeat with in_valid=0 gaps inside the runs -> identical bit sequence.
//  4. stuff_en=0, 8 ones -> 8 ones out, no stuff.
//     Then stuff_en=1 and 6 ones plus flush in the ST_STUFF cycle -> no stuff bit; next accepted 1 starts run=1.
//  5. STUFF_CNT_W=2, 4 stuff events -> stuff_count=3.
//     count_clr together with a stuff event -> stuff_count=1.
//  6. n_rst=0 for 2 cycles after 5 ones:
//     - outputs all 0 and in_ready=0 during reset.
//     - after release, 6 further ones are needed before a stuff.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit path.
package usb_tx_pkg;

    typedef enum logic {ST_RUN, ST_STUFF} stuff_state_t;

    localparam int USB_STUFF_RUN = 6;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment together yield 1.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? W'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/bit_stuffer_param.sv
// Serial bit stuffer: after RUN_LEN consecutive RUN_BIT bits, inserts one ~RUN_BIT bit
// and holds off upstream for that bit time.
module bit_stuffer_param
    import usb_tx_pkg::*;
#(
    parameter int   RUN_LEN     = USB_STUFF_RUN,
    parameter logic RUN_BIT     = 1'b1,
    parameter int   STUFF_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   shift_en,
    input  logic                   stuff_en,
    input  logic                   flush,
    input  logic                   serial_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   serial_out,
    output logic                   out_valid,
    output logic                   stuffing,
    output logic [STUFF_CNT_W-1:0] stuff_count,
    input  logic                   count_clr
);

    localparam int RUN_W = $clog2(RUN_LEN + 1);

    stuff_state_t     state;
    stuff_state_t     state_next;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_next;
    logic             serial_next;
    logic             out_valid_next;
    logic             stuffing_next;
    logic             stuff_inc;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next     = state;
        run_next       = run;
        serial_next    = serial_out;
        out_valid_next = 1'b0;
        stuffing_next  = 1'b0;
        stuff_inc      = 1'b0;
        in_ready       = 1'b0;

        if (!n_rst) begin
            in_ready = 1'b0;
        end else if (flush) begin
            // Abort drops any pending stuff bit without touching the stuff counter.
            state_next = ST_RUN;
            run_next   = '0;
        end else begin
            case (state)
                ST_RUN: begin
                    in_ready = shift_en;
                    if (!stuff_en) begin
                        run_next = '0;
                    end
                    if (shift_en && in_valid) begin
                        serial_next    = serial_in;
                        out_valid_next = 1'b1;
                        if (serial_in != RUN_BIT) begin
                            run_next = '0;
                        end else if (stuff_en && (run == RUN_W'(RUN_LEN - 1))) begin
                            run_next   = '0;
                            state_next = ST_STUFF;
                        end else if (stuff_en) begin
                            run_next = run + RUN_W'(1);
                        end
                    end
                end
                ST_STUFF: begin
                    // The scheduled stuff bit goes out even if stuff_en has since dropped.
                    if (shift_en) begin
                        serial_next    = ~RUN_BIT;
                        out_valid_next = 1'b1;
                        stuffing_next  = 1'b1;
                        stuff_inc      = 1'b1;
                        run_next       = '0;
                        state_next     = ST_RUN;
                    end
                end
                default: begin
                    state_next = ST_RUN;
                    run_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= ST_RUN;
            run        <= '0;
            serial_out <= 1'b0;
            out_valid  <= 1'b0;
            stuffing   <= 1'b0;
        end else begin
            state      <= state_next;
            run        <= run_next;
            serial_out <= serial_next;
            out_valid  <= out_valid_next;
            stuffing   <= stuffing_next;
        end
    end

    sat_counter #(
        .W (STUFF_CNT_W)
    ) u_stuff_cnt (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (count_clr),
        .inc   (stuff_inc),
        .count (stuff_count)
    );

endmodule
